slow_mem_responder: RTL and testbench

Synthesizable responder for the 128-bit cache-line memory interface driven by the instruction and data caches. It services one line read or line write at a time after a configurable latency, and signals completion with a single-cycle `mem_ready` pulse. One instance per cache (I-side and D-side) stands in for slow main memory in FPGA builds and in the system bench. Storage is a line-wide array indexed by the low bits of the line address.

---
 rtl/slow_mem_pkg.sv | 24 ++
 rtl/slow_mem_lfsr.sv | 28 ++
 rtl/slow_mem_responder.sv | 149 ++++++++++++++
 tb/tb_slow_mem_responder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slow_mem_pkg.sv
// rtl/slow_mem_pkg.sv - shared types and constants for slow_mem_responder
// Used by slow_mem_responder and, when SLOW_MEM_RANDOM_LATENCY_EN is defined, slow_mem_lfsr.
package slow_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESP    = 2'd2,
    RECOVER = 2'd3
  } slow_mem_state_t;

  localparam int LINE_W      = 128;
  localparam int LINE_ADDR_W = 28;
  localparam int CNT_W       = 9;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/slow_mem_lfsr.sv
// rtl/slow_mem_lfsr.sv - latency jitter source, built only with SLOW_MEM_RANDOM_LATENCY_EN
// Fibonacci LFSR advanced once per enable, synchronously reset to the seed.
`ifdef SLOW_MEM_RANDOM_LATENCY_EN
module slow_mem_lfsr
  import slow_mem_pkg::*;
(
  input  logic       clk,
  input  logic       proc_reset,
  input  logic       en,
  output logic [7:0] state
);

  logic [7:0] state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (en) state_d = lfsr_next(state_q);
  end

  always_ff @(posedge clk) begin
    if (proc_reset) state_q <= LFSR_SEED;
    else            state_q <= state_d;
  end

  assign state = state_q;

endmodule
`endif

// File: rtl/slow_mem_responder.sv
// rtl/slow_mem_responder.sv - fixed-latency 128-bit line memory responder
// Optional latency jitter via SLOW_MEM_RANDOM_LATENCY_EN.
module slow_mem_responder
  import slow_mem_pkg::*;
#(
  parameter int LATENCY  = 8,
  parameter int RECOVERY = 2,
  parameter int AW       = 10
) (
  input  logic                   clk,
  input  logic                   proc_reset,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [LINE_ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0]      mem_wdata,
  output logic [LINE_W-1:0]      mem_rdata,
  output logic                   mem_ready,
  output logic                   busy,
  output logic                   err
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] REC_LOAD = (RECOVERY > 0) ? CNT_W'(RECOVERY - 1) : '0;

  slow_mem_state_t   state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              is_write_q, is_write_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [LINE_W-1:0] rdata_q;

  logic [LINE_W-1:0] mem_array [2**AW];

  logic              accept;
  logic              can_accept;
  logic              rd_en;
  logic              mem_we;
  logic [CNT_W-1:0]  lat_load;

  logic unused_addr;
  assign unused_addr = ^mem_addr[LINE_ADDR_W-1:AW];

`ifdef SLOW_MEM_RANDOM_LATENCY_EN
  logic [7:0] lfsr_state;
  logic       unused_lfsr;

  slow_mem_lfsr u_lfsr (
    .clk        (clk),
    .proc_reset (proc_reset),
    .en         (accept),
    .state      (lfsr_state)
  );

  // The pre-advance value sets this request's extra latency.
  assign lat_load    = LAT_LOAD + {{(CNT_W-3){1'b0}}, lfsr_state[2:0]};
  assign unused_lfsr = ^lfsr_state[7:3];
`else
  assign lat_load = LAT_LOAD;
`endif

  // The edge that expires the recovery window doubles as an acceptance point,
  // so back-to-back requests are spaced LATENCY+1+RECOVERY edges apart.
  assign can_accept = (state_q == IDLE) || ((state_q == RECOVER) && (cnt_q == '0));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_write_d = is_write_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    accept     = 1'b0;
    rd_en      = 1'b0;
    mem_we     = 1'b0;

    case (state_q)
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          rd_en   = !is_write_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        mem_we = is_write_q;
        if (RECOVERY == 0) begin
          state_d = IDLE;
        end else begin
          state_d = RECOVER;
          cnt_d   = REC_LOAD;
        end
      end
      RECOVER: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: ;
    endcase

    if (can_accept) begin
      if (mem_read && mem_write) begin
        err_d = 1'b1;
      end else if (mem_read || mem_write) begin
        accept     = 1'b1;
        state_d    = BUSY;
        cnt_d      = lat_load;
        is_write_d = mem_write;
        idx_d      = mem_addr[AW-1:0];
        wdata_d    = mem_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_write_q <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_write_q <= is_write_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
    end
  end

  // Array has no reset; a reset landing on the RESP edge still blocks the commit.
  always_ff @(posedge clk) begin
    if (mem_we && !proc_reset) mem_array[idx_q] <= wdata_q;
  end

  always_ff @(posedge clk) begin
    if (proc_reset) rdata_q <= '0;
    else if (rd_en) rdata_q <= mem_array[idx_q];
  end

  assign mem_ready = (state_q == RESP) && !proc_reset;
  assign busy      = (state_q != IDLE) && !proc_reset;
  assign err       = err_q && !proc_reset;
  assign mem_rdata = proc_reset ? '0 : rdata_q;

endmodule

// File: tb/tb_slow_mem_responder.sv
// tb/tb_slow_mem_responder.sv - directed self-checking bench for slow_mem_responder
// Define SLOW_MEM_RANDOM_LATENCY_EN to also exercise the jittered latency.
module tb_slow_mem_responder;

  logic         clk = 1'b0;
  logic         proc_reset;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  logic         busy;
  logic         err;

  int passed = 0;
  int total  = 0;

  localparam logic [127:0] D1 = 128'hDEADBEEF_00000000_00000000_00000001;
  localparam logic [127:0] D2 = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] D3 = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] DA = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
  localparam logic [127:0] DB = 128'hBBBBBBBB_BBBBBBBB_BBBBBBBB_BBBBBBBB;

  slow_mem_responder #(
    .LATENCY  (8),
    .RECOVERY (2),
    .AW       (10)
  ) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

`ifdef SLOW_MEM_RANDOM_LATENCY_EN
  logic [7:0] lfsr_m;
`endif

  task automatic reseed_model();
`ifdef SLOW_MEM_RANDOM_LATENCY_EN
    lfsr_m = 8'hA5;
`endif
  endtask

  function automatic int exp_lat();
`ifdef SLOW_MEM_RANDOM_LATENCY_EN
    int e;
    e = 8 + int'(lfsr_m[2:0]);
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    return e;
`else
    return 8;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    proc_reset = 1'b1;
    repeat (n) step();
    proc_reset = 1'b0;
    reseed_model();
  endtask

  // Counts edges after the current one until mem_ready is seen (bounded).
  task automatic wait_ready(output int n);
    n = 0;
    while (!mem_ready && n < 400) begin
      step();
      n++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 50) begin
      step();
      n++;
    end
    chk1({tag, "_idle"}, busy, 1'b0);
  endtask

  // Raises a request, checks the acceptance-to-ready latency, leaves DUT in RESP.
  task automatic run_op(input logic rd, input logic wr, input logic [27:0] a,
                        input logic [127:0] d, input string tag);
    int el;
    int lat;
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = a;
    mem_wdata = d;
    el = exp_lat();
    step();
    wait_ready(lat);
    chki({tag, "_lat"}, lat, el);
  endtask

  task automatic release_req(input string tag);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    wait_idle(tag);
  endtask

  initial begin
    int   lat;
    int   el;
    int   gap;
    logic saw;

    proc_reset = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    reseed_model();
    step();
    do_reset(2);

    chk1("rst_ready", mem_ready, 1'b0);
    chk1("rst_busy",  busy,      1'b0);
    chk1("rst_err",   err,       1'b0);
    chkw("rst_rdata", mem_rdata, 128'h0);

    // Write then read the same line.
    run_op(1'b0, 1'b1, 28'h0000040, D1, "wr40");
    chk1("wr40_busy", busy, 1'b1);
    chkw("wr40_rdata_unchanged", mem_rdata, 128'h0);
    release_req("wr40");

    run_op(1'b0, 1'b1, 28'h0000005, D3, "wr05");
    release_req("wr05");

    run_op(1'b1, 1'b0, 28'h0000040, D1, "rd40");
    chkw("rd40_data", mem_rdata, D1);
    mem_read = 1'b0;
    step();
    chk1("rd40_single_pulse", mem_ready, 1'b0);
    chkw("rd40_data_held", mem_rdata, D1);
    wait_idle("rd40");

    // Aliasing: index 3 reached through two different line addresses.
    run_op(1'b0, 1'b1, 28'h0000003, D2, "wr003");
    release_req("wr003");
    run_op(1'b1, 1'b0, 28'h0000403, 128'h0, "rd403");
    chkw("rd403_alias", mem_rdata, D2);

    // Conflicting request inside the recovery window is ignored without err.
    mem_read = 1'b0;
    step();
    mem_read  = 1'b1;
    mem_write = 1'b1;
    step();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    step();
    chk1("recover_conflict_no_err", err, 1'b0);
    wait_idle("recover_conflict");

    // Held read: pulses spaced LATENCY+1+RECOVERY edges, never back-to-back.
    run_op(1'b1, 1'b0, 28'h0000040, 128'h0, "hold0");
    chkw("hold0_data", mem_rdata, D1);
    for (int i = 0; i < 2; i++) begin
      el  = 1 + 2 + exp_lat();
      gap = 0;
      do begin
        step();
        gap++;
      end while (!mem_ready && gap < 400);
      chki($sformatf("hold_gap%0d", i), gap, el);
    end
    chkw("hold_data", mem_rdata, D1);
    release_req("hold");

    // Protocol error in IDLE.
    mem_read  = 1'b1;
    mem_write = 1'b1;
    mem_addr  = 28'h0000040;
    step();
    chk1("both_err", err, 1'b1);
    chk1("both_not_busy", busy, 1'b0);
    saw = 1'b0;
    repeat (12) begin
      step();
      saw = saw | mem_ready;
    end
    chk1("both_no_ready", saw, 1'b0);
    mem_read  = 1'b0;
    mem_write = 1'b0;
    step();
    run_op(1'b1, 1'b0, 28'h0000003, 128'h0, "rd003_after_err");
    chkw("rd003_data", mem_rdata, D2);
    release_req("rd003");
    chk1("err_sticky", err, 1'b1);
    do_reset(1);
    chk1("err_cleared", err, 1'b0);

    // Reset three cycles into a write: write is abandoned.
    mem_write = 1'b1;
    mem_addr  = 28'h0000005;
    mem_wdata = DA;
    el = exp_lat();
    step();
    step();
    step();
    proc_reset = 1'b1;
    #1;
    chk1("rstbusy_during_ready", mem_ready, 1'b0);
    chk1("rstbusy_during_busy",  busy,      1'b0);
    chkw("rstbusy_during_rdata", mem_rdata, 128'h0);
    step();
    proc_reset = 1'b0;
    mem_write  = 1'b0;
    reseed_model();
    chk1("rstbusy_after_ready", mem_ready, 1'b0);
    chk1("rstbusy_after_busy",  busy,      1'b0);
    chk1("rstbusy_after_err",   err,       1'b0);
    chkw("rstbusy_after_rdata", mem_rdata, 128'h0);
    run_op(1'b1, 1'b0, 28'h0000005, 128'h0, "rd05_a");
    chkw("rd05_old_after_busy_reset", mem_rdata, D3);
    release_req("rd05_a");

    // Reset coinciding with the RESP edge of a write.
    run_op(1'b0, 1'b1, 28'h0000005, DB, "wr05_resp_rst");
    proc_reset = 1'b1;
    step();
    proc_reset = 1'b0;
    mem_write  = 1'b0;
    reseed_model();
    chk1("resp_rst_busy", busy, 1'b0);
    run_op(1'b1, 1'b0, 28'h0000005, 128'h0, "rd05_b");
    chkw("rd05_old_after_resp_reset", mem_rdata, D3);
    release_req("rd05_b");

    // Four reads from a fresh seed; latency follows the model.
    do_reset(1);
    run_op(1'b1, 1'b0, 28'h0000040, 128'h0, "seq0");
    chkw("seq0_data", mem_rdata, D1);
    release_req("seq0");
    run_op(1'b1, 1'b0, 28'h0000003, 128'h0, "seq1");
    chkw("seq1_data", mem_rdata, D2);
    release_req("seq1");
    run_op(1'b1, 1'b0, 28'h0000805, 128'h0, "seq2");
    chkw("seq2_data", mem_rdata, D3);
    release_req("seq2");
    run_op(1'b1, 1'b0, 28'hFFFF840, 128'h0, "seq3");
    chkw("seq3_data", mem_rdata, D1);
    release_req("seq3");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
